// File: rtl/lcd_bus_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_if
//
// Groups the request handshake and the LCD pin bus of lcd_bus_driver.
//
// Signals:
//   start    request to transfer one byte (sampled only while ready=1)
//   rs_in    register select for the request: 0 = command, 1 = data
//   rw_in    read/write for the request, passed through unchanged
//   data_in  byte to transfer
//   ready    driver idle, start may be accepted this cycle
//   lcd_e    LCD enable strobe
//   lcd_rs   LCD register select
//   lcd_rw   LCD read/write
//   lcd_db   LCD data bus
//
// Modports:
//   master  request side (drives start/rs_in/rw_in/data_in)
//   slave   the driver (drives ready and the LCD pins)
// -----------------------------------------------------------------------------
interface lcd_bus_if;
   logic       start;
   logic       rs_in;
   logic       rw_in;
   logic [7:0] data_in;
   logic       ready;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_db;

   modport master (
      output start, rs_in, rw_in, data_in,
      input  ready, lcd_e, lcd_rs, lcd_rw, lcd_db
   );

   modport slave (
      input  start, rs_in, rw_in, data_in,
      output ready, lcd_e, lcd_rs, lcd_rw, lcd_db
   );
endinterface

// File: rtl/lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// lcd_bus_driver
//
// Drives one byte at a time onto an HD44780-style parallel LCD bus: waits a
// power-up interval after reset, then for every accepted request sets up
// RS/RW/DB, strobes E, holds the bus and waits out the LCD execution time.
// Clear (0x01) and home (0x02/0x03) commands get the long execution wait.
//
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  synchronous, active-high reset
//   bus  lcd_bus_if.slave: start/rs_in/rw_in/data_in in,
//        ready/lcd_e/lcd_rs/lcd_rw/lcd_db out (all registered)
//
// Parameters (cycles, each 1 .. 2^20-1):
//   T_POWERUP    idle time after reset before the first transfer
//   T_SETUP      bus stable with E low before the E rise
//   T_PULSE      E high time
//   T_HOLD       bus held after the E fall
//   T_EXEC       execution wait for normal commands and data
//   T_EXEC_LONG  execution wait for clear/home commands
// -----------------------------------------------------------------------------
module lcd_bus_driver #(
   parameter int T_POWERUP   = 750000,
   parameter int T_SETUP     = 4,
   parameter int T_PULSE     = 12,
   parameter int T_HOLD      = 4,
   parameter int T_EXEC      = 2500,
   parameter int T_EXEC_LONG = 82000
) (
   input  logic      clk,
   input  logic      rst,
   lcd_bus_if.slave  bus
);

   localparam logic [19:0] C_POWERUP   = 20'(T_POWERUP);
   localparam logic [19:0] C_SETUP     = 20'(T_SETUP);
   localparam logic [19:0] C_PULSE     = 20'(T_PULSE);
   localparam logic [19:0] C_HOLD      = 20'(T_HOLD);
   localparam logic [19:0] C_EXEC      = 20'(T_EXEC);
   localparam logic [19:0] C_EXEC_LONG = 20'(T_EXEC_LONG);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t      state, state_nxt;
   logic [19:0] cnt, cnt_nxt;

   // Output registers; rs_q/rw_q/db_q double as the request latch.
   logic       ready_q, ready_nxt;
   logic       e_q, e_nxt;
   logic       rs_q, rs_nxt;
   logic       rw_q, rw_nxt;
   logic [7:0] db_q, db_nxt;

   logic last;
   logic long_cmd;

   // The counter is loaded with the full state length on entry and the state
   // ends on the cycle it reads 1, so a state lasts exactly its parameter.
   assign last = (cnt == 20'd1);

   // Clear display (0x01) and return home (0x02, 0x03 with the don't-care
   // bit) need the long execution time; data bytes never do.
   assign long_cmd = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

   // NOTE: every variable gets a default before the case statement so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rs_nxt    = rs_q;
      rw_nxt    = rw_q;
      db_nxt    = db_q;

      case (state)
         ST_POWERUP: begin
            if (last) state_nxt = ST_IDLE;
            else      cnt_nxt   = cnt - 20'd1;
         end

         // Only IDLE looks at start, so requests while busy are simply dropped.
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_SETUP;
               cnt_nxt   = C_SETUP;
               rs_nxt    = bus.rs_in;
               rw_nxt    = bus.rw_in;
               db_nxt    = bus.data_in;
            end
         end

         ST_SETUP: begin
            if (last) begin
               state_nxt = ST_PULSE;
               cnt_nxt   = C_PULSE;
            end else begin
               cnt_nxt = cnt - 20'd1;
            end
         end

         ST_PULSE: begin
            if (last) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = C_HOLD;
            end else begin
               cnt_nxt = cnt - 20'd1;
            end
         end

         ST_HOLD: begin
            if (last) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = long_cmd ? C_EXEC_LONG : C_EXEC;
            end else begin
               cnt_nxt = cnt - 20'd1;
            end
         end

         ST_WAIT: begin
            if (last) state_nxt = ST_IDLE;
            else      cnt_nxt   = cnt - 20'd1;
         end

         default: begin
            state_nxt = ST_POWERUP;
            cnt_nxt   = C_POWERUP;
         end
      endcase

      // Outputs are decoded from the next state and registered, so they line
      // up with the state register cycle for cycle.
      ready_nxt = (state_nxt == ST_IDLE);
      e_nxt     = (state_nxt == ST_PULSE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_POWERUP;
         cnt     <= C_POWERUP;
         ready_q <= 1'b0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         rw_q    <= 1'b0;
         db_q    <= 8'h00;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= ready_nxt;
         e_q     <= e_nxt;
         rs_q    <= rs_nxt;
         rw_q    <= rw_nxt;
         db_q    <= db_nxt;
      end
   end

   assign bus.ready  = ready_q;
   assign bus.lcd_e  = e_q;
   assign bus.lcd_rs = rs_q;
   assign bus.lcd_rw = rw_q;
   assign bus.lcd_db = db_q;

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 Parameter T_POWERUP, default 750000: cycles idle after reset before the first transfer (15 ms at 50 MHz).
REQ-002 Parameter T_SETUP, default 4: cycles RS/RW/DB are stable with E low before the E rise.
REQ-003 Parameter T_PULSE, default 12: cycles E is high.
REQ-004 Parameter T_HOLD, default 4: cycles RS/RW/DB are held after the E fall.
REQ-005 Parameter T_EXEC, default 2500: execution wait for normal commands and data (50 us).
REQ-006 Parameter T_EXEC_LONG, default 82000: execution wait for clear and home commands (1.64 ms).
REQ-007 clk  in  1  system clock; all state updates on the posedge.
REQ-008 rst  in  1  reset: synchronous, active-high.
REQ-009 start  in  1  request to transfer one byte; sampled only while ready=1.
REQ-010 rs_in  in  1  register select for the request: 0 = command, 1 = data.
REQ-011 rw_in  in  1  read/write for the request; passed through unchanged.
REQ-012 data_in  in  8  byte to write, formed as {MsbOD, Out_display[6:0]} from the upstream command mux.
REQ-013 ready  out  1  driver idle; it can accept start this cycle.
REQ-014 lcd_e  out  1  LCD enable strobe.
REQ-015 lcd_rs  out  1  LCD register select.
REQ-016 lcd_rw  out  1  LCD read/write.
REQ-017 lcd_db  out  8  LCD data bus.

Function
REQ-018 All outputs shall be registered.
REQ-019 The states shall be POWERUP, IDLE, SETUP, PULSE, HOLD and WAIT, with one down-counter of 20 bits.
REQ-020 Every T_* parameter shall be at least 1 and less than 2^20; each state shall last exactly its parameter in cycles.
REQ-021 POWERUP: ready=0 and lcd_e=0 for T_POWERUP cycles, then IDLE.
REQ-022 IDLE: ready=1 and lcd_e=0.
  - start=1 at an edge latches rs_in, rw_in and data_in.
  - It then moves to SETUP with ready=0 from the next cycle.
REQ-023 start shall be ignored whenever ready=0; no queuing and no error.
REQ-024 SETUP: lcd_rs, lcd_rw and lcd_db drive the latched values and lcd_e=0 for T_SETUP cycles.
REQ-025 PULSE: lcd_e=1 for T_PULSE cycles; bus values unchanged.
REQ-026 HOLD: lcd_e=0 for T_HOLD cycles; bus values unchanged.
REQ-027 WAIT: lcd_e=0; bus values keep the last transfer.
  - Length is T_EXEC_LONG if the latched rs=0 and data is 0x01, 0x02 or 0x03.
  - Length is T_EXEC in every other case.
REQ-028 After WAIT the block shall return to IDLE; ready=1 from the first IDLE cycle.
REQ-029 Ready shall rise T_SETUP+T_PULSE+T_HOLD+T_EXEC(_LONG) cycles after the ready=0 cycle following acceptance.
REQ-030 If start is held high in IDLE, back-to-back transfers shall occur with exactly one ready=1 cycle between them.
REQ-031 data_in, rs_in and rw_in changing after acceptance shall not affect the transfer in progress.
REQ-032 lcd_e shall go high exactly once per accepted start.

Reset
REQ-033 rst=1 at an edge shall force state POWERUP, reload the counter with T_POWERUP, and set ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0 and lcd_db=0x00.
REQ-034 Reset in any state, including mid-PULSE, shall drop lcd_e low on that edge.
REQ-035 A transfer interrupted by reset shall be discarded and not retried.
REQ-036 While rst=1, outputs shall hold their reset values and start shall be ignored.

Verification (T_POWERUP=10, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=8, T_EXEC_LONG=20)
REQ-037 Reset released -> ready=0 for 10 cycles, then ready=1; lcd_e stays 0 throughout.
REQ-038 Data write (start, rs_in=1, data_in=0x41) -> lcd_rs=1 and lcd_db=0x41 for 2 cycles with lcd_e=0, then lcd_e=1 for 4 cycles, then 2 hold cycles; ready returns after 16 busy cycles.
REQ-039 Clear command (rs_in=0, data_in=0x01) -> 28 busy cycles; command 0x38 -> 16 busy cycles; data 0x01 with rs_in=1 -> 16 busy cycles.
REQ-040 start held high with data_in changed mid-transfer -> the first byte is unaffected, the second transfer starts after one ready cycle, and two lcd_e pulses are seen.
REQ-041 rst asserted on the 2nd PULSE cycle -> lcd_e=0 and lcd_db=0x00 on the next edge; 10-cycle power-up again; no further pulse.
REQ-042 start pulsed during WAIT -> ignored; no extra lcd_e pulse; ready timing unchanged.
